multdiv_sequencer: RTL and testbench

//  Multi-cycle signed 32-bit multiply/divide unit for the processor execute stage.

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/multdiv_addsub.sv | 20 ++
 rtl/multdiv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Unsigned magnitude of a two's complement value; INT_MIN maps to 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the accumulate, trial-subtract and negate steps.
module multdiv_addsub
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           carry_o
);

  logic [WIDTH:0]   bEff;
  logic [WIDTH+1:0] full;

  // Subtraction is a + ~b + 1, so carry-out high means a >= b
  assign bEff = sub_i ? ~b_i : b_i;
  assign full = {1'b0, a_i} + {1'b0, bEff} + {{(WIDTH+1){1'b0}}, sub_i};
  assign {carry_o, sum_o} = full;

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (shift-add) and divide (restoring) on one shared adder.
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ITER_DONE = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   accHi_q, accHi_d;
  logic [WIDTH-1:0] accLo_q, accLo_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             neg_q, neg_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH:0]   addA, addB, addSum;
  logic             addSub, addCarry;
  logic             start, startOp, finalize;
  logic [WIDTH:0]   remShift, mulSel;
  logic [WIDTH-1:0] negLo;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign startOp  = ctrl_MULT ? OP_MUL : OP_DIV;
  assign finalize = (cnt_q == ITER_DONE);
  assign remShift = {accHi_q[WIDTH-1:0], accLo_q[WIDTH-1]};
  assign negLo    = addSum[WIDTH-1:0];

  multdiv_addsub u_addsub (
    .a_i    (addA),
    .b_i    (addB),
    .sub_i  (addSub),
    .sum_o  (addSum),
    .carry_o(addCarry)
  );

  // Steer the shared adder: accumulate, trial subtract, or 0 - magnitude on the last edge
  always_comb begin
    addA   = '0;
    addB   = {1'b0, opB_q};
    addSub = 1'b0;
    if ((state_q == MUL) || (state_q == DIV)) begin
      if (finalize) begin
        addA   = '0;
        addB   = {1'b0, accLo_q};
        addSub = 1'b1;
      end else if (state_q == MUL) begin
        addA = accHi_q;
      end else begin
        addA   = remShift;
        addSub = 1'b1;
      end
    end
  end

  // Next-state, iteration and result logic; a start pulse always restarts from scratch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    opB_d     = opB_q;
    neg_d     = neg_q;
    divZero_d = divZero_q;
    result_d  = result_q;
    exc_d     = exc_q;
    mulSel    = accLo_q[0] ? addSum : accHi_q;

    if (start) begin
      state_d   = (startOp == OP_MUL) ? MUL : DIV;
      cnt_d     = '0;
      accHi_d   = '0;
      accLo_d   = magnitude(data_operandA);
      opB_d     = magnitude(data_operandB);
      neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divZero_d = (startOp == OP_DIV) && (data_operandB == '0);
      result_d  = '0;
      exc_d     = 1'b0;
    end else begin
      case (state_q)
        MUL: begin
          if (finalize) begin
            state_d  = DONE;
            result_d = neg_q ? negLo : accLo_q;
            exc_d    = (|accHi_q[WIDTH-1:0]) |
                       (neg_q ? (accLo_q > INT_MIN) : accLo_q[WIDTH-1]);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            accHi_d = {1'b0, mulSel[WIDTH:1]};
            accLo_d = {mulSel[0], accLo_q[WIDTH-1:1]};
          end
        end
        DIV: begin
          if (divZero_q) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end else if (finalize) begin
            state_d  = DONE;
            result_d = neg_q ? negLo : accLo_q;
            exc_d    = !neg_q && (accLo_q == INT_MIN);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (addCarry) begin
              accHi_d = addSum;
              accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
            end else begin
              accHi_d = remShift;
              accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opB_q     <= '0;
      neg_q     <= 1'b0;
      divZero_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      opB_q     <= opB_d;
      neg_q     <= neg_d;
      divZero_q <= divZero_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer against a plain-arithmetic reference model.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int total = 0;
  int bad   = 0;

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: signed 64-bit product or truncating signed quotient
  task automatic refModel(input logic isMul, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc);
    longint prod;
    logic [31:0] low;
    if (isMul) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      low  = prod[31:0];
      res  = low;
      exc  = (prod != longint'($signed(low)));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      res = $signed(a) / $signed(b);
      exc = 1'b0;
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 1000));
      6:       return {24'hFF_FFFF, 8'($urandom())};
      default: return $urandom();
    endcase
  endfunction

  // Caller is at a negedge; the following posedge is the start edge E0
  task automatic startPulse(input logic doMul, input logic doDiv,
                            input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = doMul;
    ctrl_DIV      = doDiv;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic awaitResult(input string tag, input logic [31:0] expRes, input logic expExc,
                             input int expLat, input logic doHold);
    int lat = 0;
    checkOutput({tag, ".busyStart"}, 32'(busy), 32'd1);
    checkOutput({tag, ".clrRes"}, data_result, 32'd0);
    checkOutput({tag, ".clrExc"}, 32'(data_exception), 32'd0);
    while (data_resultRDY !== 1'b1 && lat < 80) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".result"}, data_result, expRes);
    checkOutput({tag, ".exc"}, 32'(data_exception), 32'(expExc));
    checkOutput({tag, ".busyAtRdy"}, 32'(busy), 32'd0);
    if (doHold) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput({tag, ".rdyOneCycle"}, 32'(data_resultRDY), 32'd0);
      checkOutput({tag, ".holdRes"}, data_result, expRes);
      checkOutput({tag, ".holdExc"}, 32'(data_exception), 32'(expExc));
      checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic doMul, input logic doDiv,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    logic        expExc;
    int          expLat;
    refModel(doMul, a, b, expRes, expExc);
    expLat = (!doMul && b == 32'd0) ? 1 : 33;
    startPulse(doMul, doDiv, a, b);
    awaitResult(tag, expRes, expExc, expLat, 1'b1);
  endtask

  // Asynchronous reset while idle must clear held outputs
  task automatic idleReset(input string tag);
    reset = 1'b1;
    #2;
    checkOutput({tag, ".res"}, data_result, 32'd0);
    checkOutput({tag, ".exc"}, 32'(data_exception), 32'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Main sequence: reset, directed cases, abort/reset cases, then random operations
  initial begin
    int rdySeen;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("reset.res", data_result, 32'd0);
    checkOutput("reset.exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus("mul7xm6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    applyStimulus("mulOvf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    applyStimulus("divm100by7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    applyStimulus("divByZero", 1'b0, 1'b1, 32'd5, 32'd0);
    applyStimulus("divMinByM1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idleReset("idleReset");
    applyStimulus("bothCtrl", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFA);
    applyStimulus("mulMinBy1", 1'b1, 1'b0, 32'h8000_0000, 32'd1);

    // Divide issued on E10 of a multiply replaces it
    rdySeen = 0;
    startPulse(1'b1, 1'b0, 32'd3, 32'd4);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdySeen++;
    end
    startPulse(1'b0, 1'b1, 32'd20, 32'd4);
    awaitResult("abort", 32'd5, 1'b0, 33, 1'b1);
    checkOutput("abort.noEarlyRdy", 32'(rdySeen), 32'd0);

    // Start issued during the ready cycle restarts immediately
    startPulse(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    awaitResult("doneRestartA", 32'hFFFF_FFD6, 1'b0, 33, 1'b0);
    startPulse(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    awaitResult("doneRestartB", 32'hFFFF_FFF2, 1'b0, 33, 1'b1);

    // Reset at E15 drops the operation
    startPulse(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777);
    repeat (14) begin
      @(posedge clock);
      @(negedge clock);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("midReset.res", data_result, 32'd0);
    checkOutput("midReset.exc", 32'(data_exception), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rdySeen = 0;
    repeat (50) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) rdySeen++;
    end
    checkOutput("midReset.noRdy", 32'(rdySeen), 32'd0);
    checkOutput("midReset.idle", 32'(busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic doMul;
      logic [31:0] a, b;
      doMul = 1'($urandom_range(0, 1));
      a     = pickOperand();
      b     = pickOperand();
      applyStimulus(doMul ? "randMul" : "randDiv", doMul, !doMul, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
